// File: rtl/ysyx_22041752_div_pkg.sv
// ---------------------------------------------------------------------------
// ysyx_22041752_div_pkg
// Shared definitions for the divider sequencing controller:
//   - XLEN and the core latency constant (XLEN+2 div_valid cycles)
//   - controller state encoding (IDLE/BUSY/DONE)
//   - req_op encodings and small decode helpers
// ---------------------------------------------------------------------------
package ysyx_22041752_div_pkg;

  localparam int XLEN        = 64;
  localparam int DIV_LATENCY = XLEN + 2;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  // Signed ops are DIV and REM (op[0] clear).
  function automatic logic op_is_signed(input logic [1:0] op);
    return (op == OP_DIV) || (op == OP_REM);
  endfunction

  // Remainder ops select the core remainder instead of the quotient.
  function automatic logic op_is_rem(input logic [1:0] op);
    return (op == OP_REM) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/ysyx_22041752_div_opfmt.sv
// ---------------------------------------------------------------------------
// ysyx_22041752_div_opfmt
// Combinational operand/result formatting for RV64M divide ops.
// Ports:
//   word, op, src1, src2 : incoming request fields
//   op_signed            : signed mode derived from op
//   dividend, divisor    : operands for the core (W ops extend bits [31:0])
//   res_word, res_raw    : selected core result and its W flag
//   res_data             : final rd value (W ops sign-extend bits [31:0])
// ---------------------------------------------------------------------------
module ysyx_22041752_div_opfmt #(
  parameter int XLEN = 64
) (
  input  logic            word,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  input  logic            res_word,
  input  logic [XLEN-1:0] res_raw,
  output logic            op_signed,
  output logic [XLEN-1:0] dividend,
  output logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] res_data
);
  import ysyx_22041752_div_pkg::*;

  logic ext1;
  logic ext2;

  // W ops extend the low word: sign-extend for signed ops, zero-extend
  // otherwise. Results of W ops are always sign-extended from bit 31.
  always_comb begin
    op_signed = op_is_signed(op);
    ext1      = op_signed & src1[31];
    ext2      = op_signed & src2[31];
    if (word) begin
      dividend = {{(XLEN-32){ext1}}, src1[31:0]};
      divisor  = {{(XLEN-32){ext2}}, src2[31:0]};
    end else begin
      dividend = src1;
      divisor  = src2;
    end
    if (res_word) begin
      res_data = {{(XLEN-32){res_raw[31]}}, res_raw[31:0]};
    end else begin
      res_data = res_raw;
    end
  end

endmodule

// File: rtl/ysyx_22041752_div_ctrl.sv
// ---------------------------------------------------------------------------
// ysyx_22041752_div_ctrl
// Sequences RV64M divide/remainder requests onto an iterative divider core.
// Ports:
//   clk, reset (async, active-low), flush
//   req_*   : EX request handshake (op, word, src1, src2)
//   resp_*  : result handshake back to the pipeline
//   div_*   : core interface (start/hold, signed mode, flush, operands,
//             result valid, quotient, remainder)
// The core result is always captured into a one-entry cache, and DONE
// reads its response from that cache; a DIV/REM pair on the same operands
// therefore completes the second op straight from the cache.
// ---------------------------------------------------------------------------
module ysyx_22041752_div_ctrl #(
  parameter int XLEN = ysyx_22041752_div_pkg::XLEN
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [1:0]      req_op,
  input  logic            req_word,
  input  logic [XLEN-1:0] req_src1,
  input  logic [XLEN-1:0] req_src2,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_data,
  output logic            div_valid,
  output logic            div_signed,
  output logic            div_flush,
  output logic [XLEN-1:0] div_dividend,
  output logic [XLEN-1:0] div_divisor,
  input  logic            div_out_valid,
  input  logic [XLEN-1:0] div_quotient,
  input  logic [XLEN-1:0] div_remainder
);
  import ysyx_22041752_div_pkg::*;

  div_state_e state;
  div_state_e state_next;

  logic            accept;
  logic            capture;
  logic            cache_hit;

  logic            word_q;
  logic            rem_q;
  logic            signed_q;
  logic [XLEN-1:0] src1_q;
  logic [XLEN-1:0] src2_q;
  logic [XLEN-1:0] dividend_q;
  logic [XLEN-1:0] divisor_q;

  logic            cache_valid;
  logic            cache_signed;
  logic            cache_word;
  logic [XLEN-1:0] cache_src1;
  logic [XLEN-1:0] cache_src2;
  logic [XLEN-1:0] cache_quo;
  logic [XLEN-1:0] cache_rem;

  logic            req_signed;
  logic [XLEN-1:0] fmt_dividend;
  logic [XLEN-1:0] fmt_divisor;
  logic [XLEN-1:0] sel_result;
  logic [XLEN-1:0] fmt_result;

  assign sel_result = rem_q ? cache_rem : cache_quo;

  ysyx_22041752_div_opfmt #(
    .XLEN(XLEN)
  ) u_opfmt (
    .word     (req_word),
    .op       (req_op),
    .src1     (req_src1),
    .src2     (req_src2),
    .res_word (word_q),
    .res_raw  (sel_result),
    .op_signed(req_signed),
    .dividend (fmt_dividend),
    .divisor  (fmt_divisor),
    .res_data (fmt_result)
  );

  // The cache key is the raw request; quotient vs remainder is not part of
  // it because both are captured together.
  assign cache_hit = cache_valid
                  && (cache_src1   == req_src1)
                  && (cache_src2   == req_src2)
                  && (cache_signed == req_signed)
                  && (cache_word   == req_word);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= DIV_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and handshake outputs. Flush overrides everything, and a
  // flushed completion must not reach the cache, so capture is gated too.
  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    div_valid  = 1'b0;
    accept     = 1'b0;
    capture    = 1'b0;
    case (state)
      DIV_IDLE: begin
        req_ready = 1'b1;
        if (req_valid && !flush) begin
          accept     = 1'b1;
          state_next = cache_hit ? DIV_DONE : DIV_BUSY;
        end
      end
      DIV_BUSY: begin
        div_valid = 1'b1;
        if (div_out_valid && !flush) begin
          capture    = 1'b1;
          state_next = DIV_DONE;
        end
      end
      DIV_DONE: begin
        resp_valid = !flush;
        if (resp_ready) begin
          state_next = DIV_IDLE;
        end
      end
      default: begin
        state_next = DIV_IDLE;
      end
    endcase
    if (flush) begin
      state_next = DIV_IDLE;
    end
  end

  // Request latch and operand registers, loaded on every accept (hit or
  // miss) so the response formatting always sees the current op.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      word_q     <= 1'b0;
      rem_q      <= 1'b0;
      signed_q   <= 1'b0;
      src1_q     <= '0;
      src2_q     <= '0;
      dividend_q <= '0;
      divisor_q  <= '0;
    end else if (accept) begin
      word_q     <= req_word;
      rem_q      <= op_is_rem(req_op);
      signed_q   <= req_signed;
      src1_q     <= req_src1;
      src2_q     <= req_src2;
      dividend_q <= fmt_dividend;
      divisor_q  <= fmt_divisor;
    end
  end

  // Result cache: written only when a BUSY iteration completes unflushed.
  // Flush leaves it intact; only reset invalidates it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cache_valid  <= 1'b0;
      cache_signed <= 1'b0;
      cache_word   <= 1'b0;
      cache_src1   <= '0;
      cache_src2   <= '0;
      cache_quo    <= '0;
      cache_rem    <= '0;
    end else if (capture) begin
      cache_valid  <= 1'b1;
      cache_signed <= signed_q;
      cache_word   <= word_q;
      cache_src1   <= src1_q;
      cache_src2   <= src2_q;
      cache_quo    <= div_quotient;
      cache_rem    <= div_remainder;
    end
  end

  assign resp_data    = resp_valid ? fmt_result : '0;
  assign div_signed   = signed_q;
  assign div_dividend = dividend_q;
  assign div_divisor  = divisor_q;
  assign div_flush    = flush;

endmodule

// File: tb/tb_ysyx_22041752_div_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ysyx_22041752_div_ctrl
// Directed bench for the divider controller. A behavioural divider core
// sits next to the DUT: it counts consecutive div_valid cycles, answers in
// the 66th (or the first for divide-by-zero / divide-by-minus-one), and
// returns RISC-V quotient/remainder for its operands.
// ---------------------------------------------------------------------------
module tb_ysyx_22041752_div_ctrl;

  localparam int XLEN = 64;

  logic            clk;
  logic            reset;
  logic            flush;
  logic            req_valid;
  logic            req_ready;
  logic [1:0]      req_op;
  logic            req_word;
  logic [XLEN-1:0] req_src1;
  logic [XLEN-1:0] req_src2;
  logic            resp_valid;
  logic            resp_ready;
  logic [XLEN-1:0] resp_data;
  logic            div_valid;
  logic            div_signed;
  logic            div_flush;
  logic [XLEN-1:0] div_dividend;
  logic [XLEN-1:0] div_divisor;
  logic            div_out_valid;
  logic [XLEN-1:0] div_quotient;
  logic [XLEN-1:0] div_remainder;

  int errors = 0;
  int checks = 0;

  ysyx_22041752_div_ctrl #(.XLEN(XLEN)) dut (
    .clk          (clk),
    .reset        (reset),
    .flush        (flush),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_op       (req_op),
    .req_word     (req_word),
    .req_src1     (req_src1),
    .req_src2     (req_src2),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_data    (resp_data),
    .div_valid    (div_valid),
    .div_signed   (div_signed),
    .div_flush    (div_flush),
    .div_dividend (div_dividend),
    .div_divisor  (div_divisor),
    .div_out_valid(div_out_valid),
    .div_quotient (div_quotient),
    .div_remainder(div_remainder)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural core: counter of consecutive div_valid cycles.
  int  core_cnt;
  logic core_fast;

  always @(posedge clk or negedge reset) begin
    if (!reset) core_cnt <= 0;
    else if (!div_valid || div_flush) core_cnt <= 0;
    else core_cnt <= core_cnt + 1;
  end

  always_comb begin
    core_fast = (div_divisor == '0) || (div_signed && (div_divisor == '1));
    div_out_valid = div_valid && (core_fast || (core_cnt == XLEN + 1));
    if (div_divisor == '0) begin
      div_quotient  = '1;
      div_remainder = div_dividend;
    end else if (div_signed && (div_divisor == '1)) begin
      div_quotient  = -div_dividend;
      div_remainder = '0;
    end else if (div_signed) begin
      div_quotient  = $signed(div_dividend) / $signed(div_divisor);
      div_remainder = $signed(div_dividend) % $signed(div_divisor);
    end else begin
      div_quotient  = div_dividend / div_divisor;
      div_remainder = div_dividend % div_divisor;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Issue one request and wait for the response. lat is the cycle number of
  // the first resp_valid, counting the accept cycle as cycle 0 (-1 on timeout).
  task automatic run_op(input logic [1:0] op, input logic word,
                        input logic [63:0] s1, input logic [63:0] s2,
                        input logic complete, output int lat,
                        output logic [63:0] data, output logic [63:0] obs_dvd,
                        output logic [63:0] obs_dvs, output logic obs_sgn);
    int cyc;
    req_op    = op;
    req_word  = word;
    req_src1  = s1;
    req_src2  = s2;
    req_valid = 1'b1;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL req_ready_idle: got %b want 1", req_ready);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    obs_dvd = div_dividend;
    obs_dvs = div_divisor;
    obs_sgn = div_signed;
    cyc = 1;
    while (!resp_valid && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    lat  = resp_valid ? cyc : -1;
    data = resp_data;
    if (complete) begin
      resp_ready = 1'b1;
      @(posedge clk); #1;
      resp_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    checks++; if (req_ready !== 1'b1) begin errors++; $display("[TB] FAIL rst_req_ready: got %b want 1", req_ready); end
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_resp_valid: got %b want 0", resp_valid); end
    checks++; if (div_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_div_valid: got %b want 0", div_valid); end
    checks++; if (resp_data !== 64'h0) begin errors++; $display("[TB] FAIL rst_resp_data: got %h want 0", resp_data); end
    checks++; if (div_dividend !== 64'h0) begin errors++; $display("[TB] FAIL rst_dividend: got %h want 0", div_dividend); end
    checks++; if (div_divisor !== 64'h0) begin errors++; $display("[TB] FAIL rst_divisor: got %h want 0", div_divisor); end
    checks++; if (div_signed !== 1'b0) begin errors++; $display("[TB] FAIL rst_div_signed: got %b want 0", div_signed); end
  endtask

  task automatic test_cache_unsigned();
    int lat; logic [63:0] d, od, os; logic sg;
    run_op(2'b01, 1'b0, 64'd100, 64'd7, 1'b1, lat, d, od, os, sg);
    checks++; if (d !== 64'd14) begin errors++; $display("[TB] FAIL divu_data: got %h want %h", d, 64'd14); end
    checks++; if (lat !== 67) begin errors++; $display("[TB] FAIL divu_lat: got %0d want 67", lat); end
    checks++; if (sg !== 1'b0) begin errors++; $display("[TB] FAIL divu_signed: got %b want 0", sg); end
    run_op(2'b11, 1'b0, 64'd100, 64'd7, 1'b1, lat, d, od, os, sg);
    checks++; if (d !== 64'd2) begin errors++; $display("[TB] FAIL remu_hit_data: got %h want %h", d, 64'd2); end
    checks++; if (lat !== 1) begin errors++; $display("[TB] FAIL remu_hit_lat: got %0d want 1", lat); end
  endtask

  task automatic test_cache_signed();
    int lat; logic [63:0] d, od, os; logic sg;
    run_op(2'b00, 1'b0, 64'hFFFFFFFFFFFFFFF9, 64'd2, 1'b1, lat, d, od, os, sg);
    checks++; if (d !== 64'hFFFFFFFFFFFFFFFD) begin errors++; $display("[TB] FAIL div_neg_data: got %h want fffffffffffffffd", d); end
    checks++; if (lat !== 67) begin errors++; $display("[TB] FAIL div_neg_lat: got %0d want 67", lat); end
    checks++; if (sg !== 1'b1) begin errors++; $display("[TB] FAIL div_neg_signed: got %b want 1", sg); end
    run_op(2'b10, 1'b0, 64'hFFFFFFFFFFFFFFF9, 64'd2, 1'b1, lat, d, od, os, sg);
    checks++; if (d !== 64'hFFFFFFFFFFFFFFFF) begin errors++; $display("[TB] FAIL rem_hit_data: got %h want ffffffffffffffff", d); end
    checks++; if (lat !== 1) begin errors++; $display("[TB] FAIL rem_hit_lat: got %0d want 1", lat); end
    run_op(2'b11, 1'b0, 64'hFFFFFFFFFFFFFFF9, 64'd2, 1'b1, lat, d, od, os, sg);
    checks++; if (d !== 64'd1) begin errors++; $display("[TB] FAIL remu_miss_data: got %h want 1", d); end
    checks++; if (lat !== 67) begin errors++; $display("[TB] FAIL remu_miss_lat: got %0d want 67", lat); end
  endtask

  task automatic test_word();
    int lat; logic [63:0] d, od, os; logic sg;
    run_op(2'b00, 1'b1, 64'hFFFFFFFF80000000, 64'hFFFFFFFFFFFFFFFF, 1'b1, lat, d, od, os, sg);
    checks++; if (d !== 64'hFFFFFFFF80000000) begin errors++; $display("[TB] FAIL divw_ovf_data: got %h want ffffffff80000000", d); end
    checks++; if (lat !== 2) begin errors++; $display("[TB] FAIL divw_ovf_lat: got %0d want 2", lat); end
    checks++; if (od !== 64'hFFFFFFFF80000000) begin errors++; $display("[TB] FAIL divw_dividend: got %h want ffffffff80000000", od); end
    checks++; if (os !== 64'hFFFFFFFFFFFFFFFF) begin errors++; $display("[TB] FAIL divw_divisor: got %h want ffffffffffffffff", os); end
    run_op(2'b11, 1'b1, 64'hABCD000000000005, 64'h0000000100000000, 1'b1, lat, d, od, os, sg);
    checks++; if (d !== 64'd5) begin errors++; $display("[TB] FAIL remuw_zero_data: got %h want 5", d); end
    checks++; if (lat !== 2) begin errors++; $display("[TB] FAIL remuw_zero_lat: got %0d want 2", lat); end
    checks++; if (od !== 64'd5) begin errors++; $display("[TB] FAIL remuw_dividend: got %h want 5", od); end
    checks++; if (os !== 64'd0) begin errors++; $display("[TB] FAIL remuw_divisor: got %h want 0", os); end
    run_op(2'b01, 1'b1, 64'h12345678FFFFFFFF, 64'd1, 1'b1, lat, d, od, os, sg);
    checks++; if (d !== 64'hFFFFFFFFFFFFFFFF) begin errors++; $display("[TB] FAIL divuw_sext_data: got %h want ffffffffffffffff", d); end
    checks++; if (lat !== 67) begin errors++; $display("[TB] FAIL divuw_sext_lat: got %0d want 67", lat); end
    checks++; if (od !== 64'h00000000FFFFFFFF) begin errors++; $display("[TB] FAIL divuw_dividend: got %h want 00000000ffffffff", od); end
  endtask

  task automatic test_flush_busy();
    int lat; logic [63:0] d, od, os; logic sg; logic seen;
    req_op = 2'b01; req_word = 1'b0; req_src1 = 64'd1000; req_src2 = 64'd3;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (29) begin @(posedge clk); #1; end
    checks++; if (div_valid !== 1'b1) begin errors++; $display("[TB] FAIL flush_busy_pre: div_valid got %b want 1", div_valid); end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    checks++; if (req_ready !== 1'b1 || div_valid !== 1'b0 || resp_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL flush_busy_idle: req_ready=%b div_valid=%b resp_valid=%b want 1/0/0", req_ready, div_valid, resp_valid);
    end
    seen = 1'b0;
    repeat (5) begin @(posedge clk); #1; if (resp_valid !== 1'b0) seen = 1'b1; end
    checks++; if (seen !== 1'b0) begin errors++; $display("[TB] FAIL flush_busy_noresp: resp_valid seen=%b want 0", seen); end
    run_op(2'b01, 1'b0, 64'd1000, 64'd3, 1'b1, lat, d, od, os, sg);
    checks++; if (d !== 64'd333) begin errors++; $display("[TB] FAIL flush_retry_data: got %h want %h", d, 64'd333); end
    checks++; if (lat !== 67) begin errors++; $display("[TB] FAIL flush_retry_lat: got %0d want 67", lat); end
  endtask

  task automatic test_hold_done();
    int lat; logic [63:0] d, od, os; logic sg;
    run_op(2'b11, 1'b0, 64'd1000, 64'd3, 1'b0, lat, d, od, os, sg);
    checks++; if (d !== 64'd1 || lat !== 1) begin errors++; $display("[TB] FAIL hold_hit: data=%h lat=%0d want 1/1", d, lat); end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      checks++;
      if (resp_valid !== 1'b1 || req_ready !== 1'b0 || resp_data !== 64'd1) begin
        errors++;
        $display("[TB] FAIL hold_cycle%0d: resp_valid=%b req_ready=%b data=%h want 1/0/1", i, resp_valid, req_ready, resp_data);
      end
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin errors++; $display("[TB] FAIL hold_release: req_ready=%b resp_valid=%b want 1/0", req_ready, resp_valid); end
  endtask

  task automatic test_flush_done();
    int lat; logic [63:0] d, od, os; logic sg;
    run_op(2'b01, 1'b0, 64'd1000, 64'd3, 1'b0, lat, d, od, os, sg);
    checks++; if (d !== 64'd333 || lat !== 1) begin errors++; $display("[TB] FAIL fdone_hit: data=%h lat=%0d want 333/1", d, lat); end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("[TB] FAIL fdone_drop: resp_valid=%b req_ready=%b want 0/1", resp_valid, req_ready); end
    run_op(2'b11, 1'b0, 64'd1000, 64'd3, 1'b1, lat, d, od, os, sg);
    checks++; if (d !== 64'd1 || lat !== 1) begin errors++; $display("[TB] FAIL fdone_cache_kept: data=%h lat=%0d want 1/1", d, lat); end
  endtask

  task automatic test_reset_busy();
    int lat; logic [63:0] d, od, os; logic sg;
    req_op = 2'b01; req_word = 1'b0; req_src1 = 64'd50; req_src2 = 64'd5;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (19) begin @(posedge clk); #1; end
    #2 reset = 1'b0;
    #1;
    checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0 || div_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL arst_ctrl: req_ready=%b resp_valid=%b div_valid=%b want 1/0/0", req_ready, resp_valid, div_valid);
    end
    checks++; if (div_dividend !== 64'd0 || div_divisor !== 64'd0 || div_signed !== 1'b0 || resp_data !== 64'd0) begin
      errors++; $display("[TB] FAIL arst_data: dividend=%h divisor=%h signed=%b data=%h want 0", div_dividend, div_divisor, div_signed, resp_data);
    end
    #4 reset = 1'b1;
    @(posedge clk); #1;
    run_op(2'b11, 1'b0, 64'd1000, 64'd3, 1'b1, lat, d, od, os, sg);
    checks++; if (d !== 64'd1) begin errors++; $display("[TB] FAIL arst_repeat_data: got %h want 1", d); end
    checks++; if (lat !== 67) begin errors++; $display("[TB] FAIL arst_repeat_lat: got %0d want 67", lat); end
  endtask

  initial begin
    reset      = 1'b0;
    flush      = 1'b0;
    req_valid  = 1'b0;
    req_op     = 2'b00;
    req_word   = 1'b0;
    req_src1   = '0;
    req_src2   = '0;
    resp_ready = 1'b0;
    #12 reset = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_cache_unsigned();
    test_cache_signed();
    test_word();
    test_flush_busy();
    test_hold_done();
    test_flush_done();
    test_reset_busy();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ysyx_22041752_div_ctrl.md
# ysyx_22041752_div_ctrl

Sequencing controller between the EX stage and the iterative 64-bit divider core. It accepts RV64M divide/remainder requests over a valid/ready handshake and forms the operands, including the W-variant 32-bit extension. It holds the core's `div_valid` for the whole iteration, captures the result, and returns it over a valid/ready response. A one-entry operand cache lets a DIV/REM pair on the same operands finish without a second iteration.

## Interface
- `XLEN`, default 64: datapath width; must equal the core's width.
- `clk` in 1: clock.
- `reset` in 1: asynchronous, active-low reset.
- `flush` in 1: pipeline flush; aborts any in-flight or pending operation.
- `req_valid` in 1: EX request valid.
- `req_ready` out 1: controller can accept a request.
- `req_op` in 2: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
- `req_word` in 1: W variant (DIVW/DIVUW/REMW/REMUW).
- `req_src1` in XLEN: dividend register value.
- `req_src2` in XLEN: divisor register value.
- `resp_valid` out 1: result valid.
- `resp_ready` in 1: consumer accepts the result.
- `resp_data` out XLEN: final rd value.
- `div_valid` out 1: core start/hold.
- `div_signed` out 1: core signed mode.
- `div_flush` out 1: equals `flush`.
- `div_dividend` out XLEN: operand to core.
- `div_divisor` out XLEN: operand to core.
- `div_out_valid` in 1: core result valid.
- `div_quotient` in XLEN: core quotient.
- `div_remainder` in XLEN: core remainder.

## Operation
- States: IDLE, BUSY, DONE.
- IDLE: `req_ready`=1. A handshake with `flush`=0 latches op, word, src1, src2.
  - Cache hit → DONE.
  - Otherwise → BUSY.
- Operand forming, registered at accept:
  - Non-W: operands are src1 and src2 unchanged.
  - W, signed: sign-extend bits [31:0] of each source.
  - W, unsigned: zero-extend bits [31:0] of each source.
  - `div_signed` = ~op[0].
- BUSY: `div_valid`=1 and operands held stable. On `div_out_valid`:
  - Capture quotient and remainder into the cache.
  - Set cache valid.
  - Go to DONE.
- DONE: `resp_valid`=1. `resp_data` = quotient if op[1]=0, else remainder.
  - If word=1, `resp_data` = sign-extension of bits [31:0] of the selected value.
  - When `resp_ready`=1 → IDLE.
- Cache hit condition, all four must match the cached entry:
  - src1, src2, `div_signed`, word.
  - The quotient/remainder selection is ignored.
- `flush` has top priority in every state:
  - Next state is IDLE.
  - An aborted BUSY does not write the cache.
  - A pending DONE result is dropped.
  - The cache is not invalidated.
- `flush` and `req_valid` in the same IDLE cycle: the request is not accepted.
- Divide-by-zero and signed overflow results come from the core unchanged. Examples:
  - DIVUW by 0 → all ones.
  - REMW 5 by 0 → 5.
  - DIVW 0x80000000 by −1 → 0xFFFFFFFF80000000.

## Timing
- Reset values: state IDLE, cache valid 0, `req_ready` 1, `resp_valid` 0, `div_valid` 0, `resp_data` 0, `div_dividend`/`div_divisor` 0, `div_signed` 0.
- Accept in cycle 0 → BUSY with `div_valid` high from cycle 1.
- The core raises `div_out_valid` in its 66th consecutive `div_valid` cycle (XLEN+2). Divide-by-zero and signed-overflow cases raise it in the first cycle.
- `resp_valid` rises the cycle after `div_out_valid`:
  - Normal latency is accept + 67.
  - Special cases are accept + 2.
- Cache hit: `resp_valid` at accept + 1.
- `div_valid` is low for at least one cycle between consecutive operations, because IDLE and DONE drive it low. This guarantees the core's counter restarts.
- The result is held in DONE indefinitely while `resp_ready`=0.
- Back-to-back throughput: one operation per (latency + 1) cycles.
- An asynchronous reset assertion mid-BUSY forces IDLE immediately. Core state is then don't-care until the next `div_valid`.

## Structure
- Shared package `ysyx_22041752_div_pkg` holds:
  - the state encoding (IDLE/BUSY/DONE);
  - the `req_op` encodings;
  - `XLEN` and the core-latency constant XLEN+2.
- One sub-module: `ysyx_22041752_div_opfmt`, combinational. It performs W-variant operand extension and result sign-extension.
- The divider core is instantiated at the same level by the integrator, not inside this block.

## Test plan
- DIVU 100/7, XLEN=64 → `resp_data`=14, `resp_valid` at accept+67; then REMU 100/7 on the same operands → 2 at accept+1 (cache hit).
- DIV −7/2 → 0xFFFFFFFFFFFFFFFD; then REM on the same operands → 0xFFFFFFFFFFFFFFFF from the cache; then REMU on the same operands → full iteration (signedness miss).
- DIVW src1=0xFFFFFFFF80000000, src2=−1 → 0xFFFFFFFF80000000 at accept+2; REMUW 5/0 → 5.
- `flush` asserted in BUSY cycle 30 → IDLE next cycle, no `resp_valid`, `div_valid` low ≥1 cycle. A following identical request must miss the cache and take full latency.
- `resp_ready` held low 10 cycles in DONE → `resp_data` stable, `req_ready`=0 throughout. Flush in DONE → response dropped.
- Async `reset` low mid-BUSY, released off a clock edge → all outputs at reset values at once; cache invalid, so a repeat request takes full latency.
